float_div_seq: RTL and testbench
================================

Name: float_div_seq

Overview:
- Sequential single-precision float divider; computes out = a / b.
- Inverse companion to the combinational float multiplier in the same float library; same float_width = 32 format (sign bit 31, exp 30:23 biased 127, mantissa 22:0 with hidden 1).
- Mantissa quotient uses a restoring divider, one bit per clock. It sits behind a req/ack handshake so the GPU float unit can issue a divide and wait for it.

Parameters:
- float_width, 32: total float width. Only 32 is supported.
- div_bits, 25: quotient bits generated; 1 integer bit plus 24 fraction bits.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- req  input  1  start pulse; a, b sampled on the clk edge where req=1 and busy=0.
- a  input  32  dividend.
- b  input  32  divisor.
- busy  output  1  high while a divide is in flight.
- ack  output  1  one-cycle pulse; out is valid from this cycle.
- out  output  32  quotient; held until the next ack.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE, busy=0, ack=0, out=0, counter=0.
- Reset mid-operation: aborts immediately; no ack; latched operands are discarded.

States:
- IDLE:
  - On an edge with req=1: latch sign sa^sb, exponents ea and eb, and the special-case flags.
  - Set rem = {1,a[22:0]} and div = {1,b[22:0]}, counter = div_bits-1.
  - Go to DIVIDE; busy=1 from the next cycle.
- DIVIDE, once per edge:
  - If rem >= div: q[counter]=1 and rem = rem - div; otherwise q[counter]=0.
  - Then rem = rem << 1.
  - rem needs 25 bits; q is 25 bits.
  - When counter==0, go to NORM; otherwise counter decrements.
  - Always runs exactly 25 edges.
- NORM, one edge:
  - Write out, pulse ack=1, set busy=0, go to IDLE.
  - A new req may be accepted on the edge right after NORM, i.e. the ack cycle.

Latency:
- req sampled at edge E0 → out/ack updated at edge E26.
- ack is high from E26 to E27.
- The latency is fixed for all inputs, including special cases.

Normal result:
- If q[24]=1: mant=q[23:1], e = ea - eb + 127.
- Else: mant=q[22:0], e = ea - eb + 126.
- e is computed as signed 10-bit.
- Rounding is truncation; remaining rem and bits are dropped.
- If e >= 255: out = {sign, 8'hFF, 23'b0} (infinity).
- If e <= 0: out = 32'h0 (flush to +0; no denormals).
- Otherwise: out = {sign, e[7:0], mant}.

Special cases (zero means exp field == 0; mantissa is ignored):
- a zero, b nonzero: out = 32'h00000000.
- a nonzero, b zero: out = {sign, 8'hFF, 23'b0}.
- a zero, b zero: out = 32'h7FC00000.
- Inputs with exp 255 are treated as ordinary normals; there is no NaN/inf input handling.

Handshake:
- req while busy=1 is ignored entirely; no queueing.
- a and b may change after the accept edge without affecting the result.
- ack never asserts without a preceding accepted req.

Test Plan:
- a=0x40C00000 (6.0), b=0x40000000 (2.0), req pulse → ack exactly 26 edges later, out=0x40400000 (3.0). Then 1.0/3.0 → out=0x3EAAAAAA.
- Sweep derived from the multiplier vectors: 4600.0/2.3, -4600.0/2.3, 4600.0/-2.3, -4600.0/-2.3, 121.0/11.0, 3.61/1.9 → to_real(out) reals_near 2000.0, -2000.0, -2000.0, 2000.0, 11.0, 1.9.
- Special cases:
  - 0.0/5.0 → 0x00000000.
  - 5.0/0.0 → 0x7F800000.
  - -5.0/0.0 → 0xFF800000.
  - 0.0/0.0 → 0x7FC00000.
  - Each with ack latency 26.
- Range limits:
  - 0x7F000000/0x00800000 → 0x7F800000 (overflow).
  - 0x00800000/0x7F000000 → 0x00000000 (underflow flush).
- Handshake abuse:
  - Second req with different operands at E5 of an in-flight divide → ignored; exactly one ack, carrying the first result.
  - req during the ack cycle → accepted; next ack 26 edges later.
- Reset:
  - Drop rst at edge E10 of a divide → busy=0, out=0 immediately, no ack.
  - After release, a fresh 6.0/2.0 returns 0x40400000.

Source files
------------

// File: rtl/float_div_seq_if.sv
// Request/acknowledge bundle between the float unit and the sequential divider.
// The master issues operands with req; the slave reports busy, ack and the quotient.
interface float_div_seq_if #(
   parameter int float_width = 32
);
   logic                   req;
   logic [float_width-1:0] a;
   logic [float_width-1:0] b;
   logic                   busy;
   logic                   ack;
   logic [float_width-1:0] out;

   modport master (output req, a, b, input busy, ack, out);
   modport slave  (input req, a, b, output busy, ack, out);
endinterface

// File: rtl/float_div_seq.sv
// Sequential single-precision divider: restoring mantissa division, one quotient
// bit per clock, fixed 26-edge latency from accept to ack, truncating result.
module float_div_seq #(
   parameter int float_width = 32,
   parameter int div_bits    = 25
) (
   input  logic            clk,
   input  logic            rst,
   float_div_seq_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DIVIDE = 2'd1,
      NORM   = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic        sign_q, sign_d;
   logic [7:0]  ea_q, ea_d;
   logic [7:0]  eb_q, eb_d;
   logic        a_zero_q, a_zero_d;
   logic        b_zero_q, b_zero_d;
   logic [24:0] rem_q, rem_d;
   logic [23:0] div_q, div_d;
   logic [24:0] quo_q, quo_d;
   logic [4:0]  cnt_q, cnt_d;
   logic        busy_q, busy_d;
   logic        ack_q, ack_d;
   logic [31:0] out_q, out_d;

   logic        rem_ge_s;
   logic [24:0] diff_s;

   // Special cases take priority; otherwise normalise on the quotient MSB and clamp.
   function automatic logic [31:0] pack_result(
      input logic        sign,
      input logic [7:0]  ea,
      input logic [7:0]  eb,
      input logic        a_zero,
      input logic        b_zero,
      input logic [24:0] q
   );
      logic signed [9:0] e;
      logic [22:0]       mant;
      logic [31:0]       res;
      e    = $signed({2'b00, ea}) - $signed({2'b00, eb}) + (q[24] ? 10'sd127 : 10'sd126);
      mant = q[24] ? q[23:1] : q[22:0];
      if (a_zero && b_zero) begin
         res = 32'h7FC0_0000;
      end else if (a_zero) begin
         res = 32'h0000_0000;
      end else if (b_zero) begin
         res = {sign, 8'hFF, 23'd0};
      end else if (e >= 10'sd255) begin
         res = {sign, 8'hFF, 23'd0};
      end else if (e <= 10'sd0) begin
         res = 32'h0000_0000;
      end else begin
         res = {sign, e[7:0], mant};
      end
      return res;
   endfunction

   assign rem_ge_s = (rem_q >= {1'b0, div_q});
   assign diff_s   = rem_ge_s ? (rem_q - {1'b0, div_q}) : rem_q;

   // Next-state and datapath: accept in IDLE, one restoring step per DIVIDE edge, pack in NORM.
   always_comb begin
      state_d  = state_q;
      sign_d   = sign_q;
      ea_d     = ea_q;
      eb_d     = eb_q;
      a_zero_d = a_zero_q;
      b_zero_d = b_zero_q;
      rem_d    = rem_q;
      div_d    = div_q;
      quo_d    = quo_q;
      cnt_d    = cnt_q;
      busy_d   = busy_q;
      ack_d    = 1'b0;
      out_d    = out_q;
      case (state_q)
         IDLE: begin
            if (bus.req) begin
               sign_d   = bus.a[31] ^ bus.b[31];
               ea_d     = bus.a[30:23];
               eb_d     = bus.b[30:23];
               a_zero_d = (bus.a[30:23] == 8'd0);
               b_zero_d = (bus.b[30:23] == 8'd0);
               rem_d    = {1'b0, 1'b1, bus.a[22:0]};
               div_d    = {1'b1, bus.b[22:0]};
               quo_d    = 25'd0;
               cnt_d    = 5'(div_bits - 1);
               busy_d   = 1'b1;
               state_d  = DIVIDE;
            end else begin
               busy_d   = 1'b0;
            end
         end
         DIVIDE: begin
            // diff_s is always below the divisor, so the shift cannot overflow 25 bits.
            rem_d = {diff_s[23:0], 1'b0};
            quo_d = {quo_q[23:0], rem_ge_s};
            if (cnt_q == 5'd0) begin
               state_d = NORM;
            end else begin
               cnt_d = cnt_q - 5'd1;
            end
         end
         NORM: begin
            out_d   = pack_result(sign_q, ea_q, eb_q, a_zero_q, b_zero_q, quo_q);
            ack_d   = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers; reset aborts any divide in flight.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         sign_q   <= 1'b0;
         ea_q     <= 8'd0;
         eb_q     <= 8'd0;
         a_zero_q <= 1'b0;
         b_zero_q <= 1'b0;
         rem_q    <= 25'd0;
         div_q    <= 24'd0;
         quo_q    <= 25'd0;
         cnt_q    <= 5'd0;
         busy_q   <= 1'b0;
         ack_q    <= 1'b0;
         out_q    <= 32'd0;
      end else begin
         state_q  <= state_d;
         sign_q   <= sign_d;
         ea_q     <= ea_d;
         eb_q     <= eb_d;
         a_zero_q <= a_zero_d;
         b_zero_q <= b_zero_d;
         rem_q    <= rem_d;
         div_q    <= div_d;
         quo_q    <= quo_d;
         cnt_q    <= cnt_d;
         busy_q   <= busy_d;
         ack_q    <= ack_d;
         out_q    <= out_d;
      end
   end

   assign bus.busy = busy_q;
   assign bus.ack  = ack_q;
   assign bus.out  = out_q;

endmodule

// File: tb/tb_float_div_seq.sv
// Directed bench for float_div_seq: vector table plus handshake and reset sequences.
module tb_float_div_seq;

   logic clk;
   logic rst;
   float_div_seq_if bus_if ();

   float_div_seq dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string       name;
      logic [31:0] a;
      logic [31:0] b;
      bit          near;
      logic [31:0] exp_bits;
      real         exp_real;
   } vec_t;

   vec_t vecs[14];

   function automatic real to_real(input logic [31:0] f);
      real p;
      int  e;
      e = int'(f[30:23]);
      if (e == 0) return 0.0;
      p = 1.0 + real'(f[22:0]) / 8388608.0;
      if (e > 127) begin
         for (int i = 0; i < e - 127; i++) p = p * 2.0;
      end else begin
         for (int i = 0; i < 127 - e; i++) p = p / 2.0;
      end
      return f[31] ? -p : p;
   endfunction

   task automatic check_hex(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   task automatic check_int(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   task automatic check_near(input string name, input logic [31:0] act, input real req);
      real r;
      real d;
      r = to_real(act);
      d = (r > req) ? (r - req) : (req - r);
      checks++;
      if (d > 1.0e-4 * ((req < 0.0) ? -req : req)) begin
         errors++;
         $display("FAIL %s: got %h (%f), expected near %f", name, act, r, req);
      end
   endtask

   // Issue one request (busy must be low) and wait for ack; lat = -1 on timeout.
   task automatic do_div(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int lat);
      @(negedge clk);
      bus_if.a   = a;
      bus_if.b   = b;
      bus_if.req = 1'b1;
      @(posedge clk);
      #1 bus_if.req = 1'b0;
      lat = -1;
      res = 32'hDEAD_BEEF;
      for (int n = 1; n <= 40; n++) begin
         @(posedge clk);
         #1;
         if (bus_if.ack) begin
            lat = n;
            res = bus_if.out;
            break;
         end
      end
   endtask

   logic [31:0] res;
   int          lat;
   int          acks;

   initial begin
      vecs[0]  = '{"6/2",        32'h40C00000, 32'h40000000, 1'b0, 32'h40400000, 0.0};
      vecs[1]  = '{"1/3",        32'h3F800000, 32'h40400000, 1'b0, 32'h3EAAAAAA, 0.0};
      vecs[2]  = '{"4600/2.3",   32'h458FC000, 32'h40133333, 1'b1, 32'h0, 2000.0};
      vecs[3]  = '{"-4600/2.3",  32'hC58FC000, 32'h40133333, 1'b1, 32'h0, -2000.0};
      vecs[4]  = '{"4600/-2.3",  32'h458FC000, 32'hC0133333, 1'b1, 32'h0, -2000.0};
      vecs[5]  = '{"-4600/-2.3", 32'hC58FC000, 32'hC0133333, 1'b1, 32'h0, 2000.0};
      vecs[6]  = '{"121/11",     32'h42F20000, 32'h41300000, 1'b1, 32'h0, 11.0};
      vecs[7]  = '{"3.61/1.9",   32'h40670A3D, 32'h3FF33333, 1'b1, 32'h0, 1.9};
      vecs[8]  = '{"0/5",        32'h00000000, 32'h40A00000, 1'b0, 32'h00000000, 0.0};
      vecs[9]  = '{"5/0",        32'h40A00000, 32'h00000000, 1'b0, 32'h7F800000, 0.0};
      vecs[10] = '{"-5/0",       32'hC0A00000, 32'h00000000, 1'b0, 32'hFF800000, 0.0};
      vecs[11] = '{"0/0",        32'h00000000, 32'h00000000, 1'b0, 32'h7FC00000, 0.0};
      vecs[12] = '{"overflow",   32'h7F000000, 32'h00800000, 1'b0, 32'h7F800000, 0.0};
      vecs[13] = '{"underflow",  32'h00800000, 32'h7F000000, 1'b0, 32'h00000000, 0.0};

      rst        = 1'b0;
      bus_if.req = 1'b0;
      bus_if.a   = 32'd0;
      bus_if.b   = 32'd0;
      repeat (3) @(posedge clk);
      #1;
      check_int("reset_busy", int'(bus_if.busy), 0);
      check_int("reset_ack", int'(bus_if.ack), 0);
      check_hex("reset_out", bus_if.out, 32'h0);
      @(negedge clk) rst = 1'b1;

      foreach (vecs[i]) begin
         do_div(vecs[i].a, vecs[i].b, res, lat);
         check_int({vecs[i].name, "_lat"}, lat, 26);
         if (vecs[i].near) check_near(vecs[i].name, res, vecs[i].exp_real);
         else              check_hex(vecs[i].name, res, vecs[i].exp_bits);
         @(posedge clk);
         #1 check_int({vecs[i].name, "_ack_pulse"}, int'(bus_if.ack), 0);
      end

      // Second req at E5 with other operands is ignored.
      @(negedge clk);
      bus_if.a = 32'h40C00000; bus_if.b = 32'h40000000; bus_if.req = 1'b1;
      @(posedge clk);
      #1 bus_if.req = 1'b0;
      acks = 0;
      res  = 32'hDEAD_BEEF;
      for (int n = 1; n <= 60; n++) begin
         if (n == 5) begin
            bus_if.a = 32'h3F800000; bus_if.b = 32'h40400000; bus_if.req = 1'b1;
         end
         @(posedge clk);
         #1;
         if (n == 1) check_int("busy_in_flight", int'(bus_if.busy), 1);
         if (n == 5) bus_if.req = 1'b0;
         if (bus_if.ack) begin
            acks++;
            res = bus_if.out;
            check_int("abuse_lat", n, 26);
         end
      end
      check_int("abuse_ack_count", acks, 1);
      check_hex("abuse_out", res, 32'h40400000);

      // req during the ack cycle is accepted; next ack 26 edges later.
      do_div(32'h40C00000, 32'h40000000, res, lat);
      check_hex("b2b_first", res, 32'h40400000);
      bus_if.a = 32'h3F800000; bus_if.b = 32'h40400000; bus_if.req = 1'b1;
      @(posedge clk);
      #1 bus_if.req = 1'b0;
      lat = -1;
      for (int n = 1; n <= 40; n++) begin
         @(posedge clk);
         #1;
         if (bus_if.ack) begin
            lat = n;
            res = bus_if.out;
            break;
         end
      end
      check_int("b2b_lat", lat, 26);
      check_hex("b2b_second", res, 32'h3EAAAAAA);

      // Reset at E10 of a divide aborts it.
      @(negedge clk);
      bus_if.a = 32'h458FC000; bus_if.b = 32'h40133333; bus_if.req = 1'b1;
      @(posedge clk);
      #1 bus_if.req = 1'b0;
      repeat (10) @(posedge clk);
      rst = 1'b0;
      #1;
      check_int("abort_busy", int'(bus_if.busy), 0);
      check_hex("abort_out", bus_if.out, 32'h0);
      @(negedge clk) rst = 1'b1;
      acks = 0;
      for (int n = 0; n < 40; n++) begin
         @(posedge clk);
         #1;
         if (bus_if.ack) acks++;
      end
      check_int("abort_no_ack", acks, 0);
      do_div(32'h40C00000, 32'h40000000, res, lat);
      check_int("post_reset_lat", lat, 26);
      check_hex("post_reset_out", res, 32'h40400000);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
